stage_sequencer: RTL and testbench

- Parametrised N-stage round-robin controller that drives one-hot stage enables and advances on per-stage done pulses.
- Generalises the fixed three-stage input -> action -> display loop of the game top level.
- Adds a runtime skip mask, graceful stop, frame counting and an optional per-stage watchdog.
- Sits in the top level between the chip-enable/reset logic and the game sub-blocks.

---
 rtl/stage_sequencer_pkg.sv | 20 ++
 rtl/stage_next_pick.sv | 38 +++
 rtl/stage_sequencer.sv | 162 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the stage sequencer.
package stage_sequencer_pkg;

  localparam logic IDLE   = 1'b0;
  localparam logic ACTIVE = 1'b1;

  typedef enum logic {
    S_IDLE   = IDLE,
    S_ACTIVE = ACTIVE
  } seq_state_t;

  localparam logic [15:0] TO_CYCLES_DEF = 16'd50000;

  function automatic int stage_idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stage_next_pick.sv
// Combinational search for the lowest unskipped stage above i_cur, plus the first unskipped stage.
module stage_next_pick
  import stage_sequencer_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int SW       = 2
) (
  input  logic [N_STAGES-1:0] i_skip,
  input  logic [SW-1:0]       i_cur,
  output logic [SW-1:0]       o_next,
  output logic                o_wrap,
  output logic [SW-1:0]       o_first,
  output logic                o_any
);

  // Scan high to low so the lowest qualifying index is the last one written.
  always_comb begin
    o_next  = '0;
    o_wrap  = 1'b1;
    o_first = '0;
    o_any   = 1'b0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (!i_skip[k]) begin
        o_first = SW'(k);
        o_any   = 1'b1;
        if (k > int'(i_cur)) begin
          o_next = SW'(k);
          o_wrap = 1'b0;
        end else begin
          o_wrap = o_wrap;
        end
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// N-stage round-robin controller with skip mask, graceful stop and frame counting.
// Optional per-stage watchdog is enabled by defining STAGE_TIMEOUT_EN.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int              N_STAGES  = 3,
  parameter int              FRAME_W   = 8,
  parameter int              TO_W      = 16,
  parameter logic [TO_W-1:0] TO_CYCLES = TO_W'(TO_CYCLES_DEF)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                run_i,
  input  logic [N_STAGES-1:0]                 skip_i,
  input  logic [N_STAGES-1:0]                 done_i,
  output logic [N_STAGES-1:0]                 en_o,
  output logic [stage_idx_w(N_STAGES)-1:0]    stage_o,
  output logic                                busy_o,
  output logic                                frame_o,
  output logic [FRAME_W-1:0]                  frame_cnt_o,
  output logic                                timeout_o,
  output logic [stage_idx_w(N_STAGES)-1:0]    to_stage_o
);

  localparam int SW = stage_idx_w(N_STAGES);
  localparam logic [N_STAGES-1:0] ONE_HOT0 = N_STAGES'(1);

  seq_state_t          r_state, w_state_nx;
  logic [N_STAGES-1:0] r_en, w_en_nx;
  logic [SW-1:0]       r_stage, w_stage_nx;
  logic                r_busy, r_frame, w_frame_nx;
  logic [FRAME_W-1:0]  r_frame_cnt, w_cnt_nx;
  logic                r_to;
  logic [SW-1:0]       r_to_stage;
  logic                w_enter, w_done_act, w_wd_hit, w_adv;
  logic [SW-1:0]       w_next, w_first;
  logic                w_wrap, w_any;

  stage_next_pick #(.N_STAGES(N_STAGES), .SW(SW)) u_pick (
    .i_skip  (skip_i),
    .i_cur   (r_stage),
    .o_next  (w_next),
    .o_wrap  (w_wrap),
    .o_first (w_first),
    .o_any   (w_any)
  );

  // r_en is one-hot on the active stage, so masking done_i with it honours only that bit.
  assign w_done_act = |(done_i & r_en);
  assign w_adv      = (r_state == S_ACTIVE) && (w_done_act || w_wd_hit);

`ifdef STAGE_TIMEOUT_EN
  logic [TO_W-1:0] r_wd;

  // Watchdog restarts on every stage entry and counts ACTIVE cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd <= '0;
    end else if (w_enter || (r_state == S_IDLE)) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + TO_W'(1);
    end
  end

  assign w_wd_hit = (r_state == S_ACTIVE) && (r_wd == (TO_CYCLES - TO_W'(1))) && !w_done_act;
`else
  logic w_unused_to;
  assign w_unused_to = ^TO_CYCLES;
  assign w_wd_hit    = 1'b0;
`endif

  // Next-state, enable and frame bookkeeping.
  always_comb begin
    w_state_nx = r_state;
    w_en_nx    = r_en;
    w_stage_nx = r_stage;
    w_frame_nx = 1'b0;
    w_cnt_nx   = r_frame_cnt;
    w_enter    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run_i && w_any) begin
          w_state_nx = S_ACTIVE;
          w_en_nx    = ONE_HOT0 << w_first;
          w_stage_nx = w_first;
          w_enter    = 1'b1;
        end else begin
          w_en_nx    = '0;
          w_stage_nx = '0;
        end
      end
      S_ACTIVE: begin
        if (w_adv && !w_wrap) begin
          w_en_nx    = ONE_HOT0 << w_next;
          w_stage_nx = w_next;
          w_enter    = 1'b1;
        end else if (w_adv) begin
          w_frame_nx = 1'b1;
          w_cnt_nx   = r_frame_cnt + FRAME_W'(1);
          if (run_i && w_any) begin
            w_en_nx    = ONE_HOT0 << w_first;
            w_stage_nx = w_first;
            w_enter    = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_en_nx    = '0;
            w_stage_nx = '0;
          end
        end else begin
          w_en_nx = r_en;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_en_nx    = '0;
        w_stage_nx = '0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_en        <= '0;
      r_stage     <= '0;
      r_busy      <= 1'b0;
      r_frame     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_en        <= w_en_nx;
      r_stage     <= w_stage_nx;
      r_busy      <= |w_en_nx;
      r_frame     <= w_frame_nx;
      r_frame_cnt <= w_cnt_nx;
    end
  end

  // Sticky timeout flag; only the first offending stage is recorded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to       <= 1'b0;
      r_to_stage <= '0;
    end else if (w_wd_hit) begin
      r_to <= 1'b1;
      if (!r_to) begin
        r_to_stage <= r_stage;
      end
    end
  end

  assign en_o        = r_en;
  assign stage_o     = r_stage;
  assign busy_o      = r_busy;
  assign frame_o     = r_frame;
  assign frame_cnt_o = r_frame_cnt;
  assign timeout_o   = r_to;
  assign to_stage_o  = r_to_stage;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (N=3, FRAME_W=2, TO_CYCLES=8).
module tb_stage_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       run_i = 1'b0;
  logic [2:0] skip_i = 3'b000;
  logic [2:0] done_i = 3'b000;
  logic [2:0] en_o;
  logic [1:0] stage_o;
  logic       busy_o;
  logic       frame_o;
  logic [1:0] frame_cnt_o;
  logic       timeout_o;
  logic [1:0] to_stage_o;

  int n_pass  = 0;
  int n_total = 0;

  stage_sequencer #(
    .N_STAGES (3),
    .FRAME_W  (2),
    .TO_W     (16),
    .TO_CYCLES(16'd8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (run_i),
    .skip_i     (skip_i),
    .done_i     (done_i),
    .en_o       (en_o),
    .stage_o    (stage_o),
    .busy_o     (busy_o),
    .frame_o    (frame_o),
    .frame_cnt_o(frame_cnt_o),
    .timeout_o  (timeout_o),
    .to_stage_o (to_stage_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic [2:0] d);
    done_i = d;
    tick();
    done_i = 3'b000;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({en_o, stage_o, busy_o, frame_o, frame_cnt_o, timeout_o, to_stage_o} !== 12'h000) $display("FAIL reset_async outputs got %b need 0", {en_o, stage_o, busy_o, frame_o, frame_cnt_o, timeout_o, to_stage_o});
    else n_pass++;
    tick(); tick();
    n_total++;
    if ({en_o, stage_o, busy_o, frame_o, frame_cnt_o, timeout_o, to_stage_o} !== 12'h000) $display("FAIL reset_held outputs got %b need 0", {en_o, stage_o, busy_o, frame_o, frame_cnt_o, timeout_o, to_stage_o});
    else n_pass++;
    rst_i = 1'b0;
    tick();
    n_total++;
    if (en_o !== 3'b000) $display("FAIL idle_no_run en_o got %b need 000", en_o); else n_pass++;
  endtask

  task automatic test_basic();
    run_i = 1'b1;
    tick();
    n_total++;
    if ({en_o, stage_o, busy_o} !== {3'b001, 2'd0, 1'b1}) $display("FAIL basic_start en/stage/busy got %b need 001_00_1", {en_o, stage_o, busy_o}); else n_pass++;
    tick(); tick(); tick();
    pulse(3'b001);
    n_total++;
    if ({en_o, stage_o, frame_o} !== {3'b010, 2'd1, 1'b0}) $display("FAIL basic_h01 en/stage/frame got %b need 010_01_0", {en_o, stage_o, frame_o}); else n_pass++;
    tick(); tick();
    pulse(3'b010);
    n_total++;
    if ({en_o, stage_o} !== {3'b100, 2'd2}) $display("FAIL basic_h12 en/stage got %b need 100_10", {en_o, stage_o}); else n_pass++;
    pulse(3'b100);
    n_total++;
    if ({en_o, stage_o, frame_o, frame_cnt_o} !== {3'b001, 2'd0, 1'b1, 2'd1}) $display("FAIL basic_frame en/stage/frame/cnt got %b need 001_00_1_01", {en_o, stage_o, frame_o, frame_cnt_o}); else n_pass++;
    tick();
    n_total++;
    if ({en_o, frame_o} !== {3'b001, 1'b0}) $display("FAIL basic_frame_pulse en/frame got %b need 001_0", {en_o, frame_o}); else n_pass++;
    pulse(3'b110);
    n_total++;
    if (en_o !== 3'b001) $display("FAIL basic_nonactive_done en_o got %b need 001", en_o); else n_pass++;
    run_i = 1'b0;
    pulse(3'b001); pulse(3'b010); pulse(3'b100);
    n_total++;
    if ({en_o, stage_o, busy_o, frame_o, frame_cnt_o} !== {3'b000, 2'd0, 1'b0, 1'b1, 2'd2}) $display("FAIL basic_stop en/stage/busy/frame/cnt got %b need 000_00_0_1_10", {en_o, stage_o, busy_o, frame_o, frame_cnt_o}); else n_pass++;
  endtask

  task automatic test_skip();
    skip_i = 3'b010;
    run_i  = 1'b1;
    tick();
    n_total++;
    if (en_o !== 3'b001) $display("FAIL skip_start en_o got %b need 001", en_o); else n_pass++;
    pulse(3'b001);
    n_total++;
    if ({en_o, stage_o} !== {3'b100, 2'd2}) $display("FAIL skip_h02 en/stage got %b need 100_10", {en_o, stage_o}); else n_pass++;
    pulse(3'b100);
    n_total++;
    if ({en_o, frame_o, frame_cnt_o} !== {3'b001, 1'b1, 2'd3}) $display("FAIL skip_frame1 en/frame/cnt got %b need 001_1_11", {en_o, frame_o, frame_cnt_o}); else n_pass++;
    pulse(3'b001);
    n_total++;
    if (en_o !== 3'b100) $display("FAIL skip_h02b en_o got %b need 100", en_o); else n_pass++;
    pulse(3'b100);
    n_total++;
    if ({en_o, frame_o, frame_cnt_o} !== {3'b001, 1'b1, 2'd0}) $display("FAIL skip_wrap en/frame/cnt got %b need 001_1_00", {en_o, frame_o, frame_cnt_o}); else n_pass++;
    // skipping the active stage must not end it early
    skip_i = 3'b011;
    tick();
    n_total++;
    if (en_o !== 3'b001) $display("FAIL skip_active_held en_o got %b need 001", en_o); else n_pass++;
    skip_i = 3'b000;
    run_i  = 1'b0;
    pulse(3'b001); pulse(3'b010); pulse(3'b100);
    n_total++;
    if ({en_o, frame_cnt_o} !== {3'b000, 2'd1}) $display("FAIL skip_stop en/cnt got %b need 000_01", {en_o, frame_cnt_o}); else n_pass++;
  endtask

  task automatic test_run_drop();
    run_i = 1'b1;
    tick();
    pulse(3'b001);
    n_total++;
    if (en_o !== 3'b010) $display("FAIL drop_stage1 en_o got %b need 010", en_o); else n_pass++;
    run_i = 1'b0;
    pulse(3'b010);
    n_total++;
    if (en_o !== 3'b100) $display("FAIL drop_continue en_o got %b need 100", en_o); else n_pass++;
    pulse(3'b100);
    n_total++;
    if ({en_o, busy_o, frame_o, frame_cnt_o} !== {3'b000, 1'b0, 1'b1, 2'd2}) $display("FAIL drop_idle en/busy/frame/cnt got %b need 000_0_1_10", {en_o, busy_o, frame_o, frame_cnt_o}); else n_pass++;
    pulse(3'b111);
    tick();
    n_total++;
    if ({en_o, frame_o, frame_cnt_o} !== {3'b000, 1'b0, 2'd2}) $display("FAIL drop_done_ignored en/frame/cnt got %b need 000_0_10", {en_o, frame_o, frame_cnt_o}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_en [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    logic       exp_fr [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0] exp_ct [7] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    done_i = 3'b111;
    run_i  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_total++;
      if ({en_o, frame_o, frame_cnt_o} !== {exp_en[i], exp_fr[i], exp_ct[i]})
        $display("FAIL b2b_cycle%0d en/frame/cnt got %b need %b", i, {en_o, frame_o, frame_cnt_o}, {exp_en[i], exp_fr[i], exp_ct[i]});
      else n_pass++;
    end
    run_i = 1'b0;
    tick(); tick(); tick();
    n_total++;
    if ({en_o, frame_o, frame_cnt_o} !== {3'b000, 1'b1, 2'd1}) $display("FAIL b2b_stop en/frame/cnt got %b need 000_1_01", {en_o, frame_o, frame_cnt_o}); else n_pass++;
    done_i = 3'b000;
  endtask

  task automatic test_all_skip();
    skip_i = 3'b111;
    run_i  = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if ({en_o, busy_o, frame_o, frame_cnt_o} !== {3'b000, 1'b0, 1'b0, 2'd1}) $display("FAIL all_skip en/busy/frame/cnt got %b need 000_0_0_01", {en_o, busy_o, frame_o, frame_cnt_o}); else n_pass++;
    run_i  = 1'b0;
    skip_i = 3'b000;
    tick();
  endtask

  task automatic test_async_reset();
    run_i = 1'b1;
    tick();
    pulse(3'b001);
    pulse(3'b010);
    n_total++;
    if ({en_o, frame_cnt_o} !== {3'b100, 2'd1}) $display("FAIL areset_pre en/cnt got %b need 100_01", {en_o, frame_cnt_o}); else n_pass++;
    #2;
    rst_i = 1'b1;
    #1;
    n_total++;
    if ({en_o, stage_o, busy_o, frame_cnt_o} !== {3'b000, 2'd0, 1'b0, 2'd0}) $display("FAIL areset_mid en/stage/busy/cnt got %b need 000_00_0_00", {en_o, stage_o, busy_o, frame_cnt_o}); else n_pass++;
    run_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    run_i = 1'b1;
    tick();
    pulse(3'b001);
    n_total++;
    if (en_o !== 3'b010) $display("FAIL to_enter1 en_o got %b need 010", en_o); else n_pass++;
`ifdef STAGE_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    n_total++;
    if ({en_o, timeout_o} !== {3'b010, 1'b0}) $display("FAIL to_before en/timeout got %b need 010_0", {en_o, timeout_o}); else n_pass++;
    tick();
    n_total++;
    if ({en_o, timeout_o, to_stage_o} !== {3'b100, 1'b1, 2'd1}) $display("FAIL to_fire en/timeout/to_stage got %b need 100_1_01", {en_o, timeout_o, to_stage_o}); else n_pass++;
    pulse(3'b100);
    for (int i = 0; i < 8; i++) tick();
    n_total++;
    if ({en_o, timeout_o, to_stage_o} !== {3'b010, 1'b1, 2'd1}) $display("FAIL to_second en/timeout/to_stage got %b need 010_1_01", {en_o, timeout_o, to_stage_o}); else n_pass++;
`else
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if ({en_o, timeout_o, to_stage_o} !== {3'b010, 1'b0, 2'd0}) $display("FAIL to_absent en/timeout/to_stage got %b need 010_0_00", {en_o, timeout_o, to_stage_o}); else n_pass++;
`endif
    run_i = 1'b0;
    pulse(3'b010);
    pulse(3'b100);
    n_total++;
    if (en_o !== 3'b000) $display("FAIL to_stop en_o got %b need 000", en_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_run_drop();
    test_back_to_back();
    test_all_skip();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
